lv_wdg_scan_ctrl: RTL and testbench



---
 rtl/lv_wdg_scan_pkg.sv | 31 +++
 rtl/lv_wdg_scan_crc8.sv | 20 ++
 rtl/lv_wdg_scan_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_lv_wdg_scan_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lv_wdg_scan_pkg.sv
// Shared definitions for the LV watchdog register scanner: FSM states and the
// CRC-8 rule that the register file also uses when storing per-register CRCs.
package lv_wdg_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_CHK,
        ST_GAP
    } scan_state_e;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'hFF;

    // One MSB-first CRC step: no reflection, no final xor.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] crc8(input logic [7:0] data);
        logic [7:0] crc;
        crc = CRC8_INIT;
        for (int i = 7; i >= 0; i--) begin
            crc = crc8_step(crc, data[i]);
        end
        return crc;
    endfunction

endpackage

// File: rtl/lv_wdg_scan_crc8.sv
// Combinational CRC-8 over a DW-bit word, built from the shared package step.
module lv_wdg_scan_crc8
    import lv_wdg_scan_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] data,
    output logic [7:0]    crc
);

    always_comb begin
        // NOTE: crc gets its value before the loop on every evaluation, so no latch is inferred.
        crc = CRC8_INIT;
        // NOTE: blocking assignments chain the bit steps combinationally; registers elsewhere use <=.
        for (int i = DW - 1; i >= 0; i--) begin
            crc = crc8_step(crc, data[i]);
        end
    end

endmodule

// File: rtl/lv_wdg_scan_ctrl.sv
// Watchdog register scanner: walks the address window, checks stored CRCs and
// detects missing acks. CRC comparison exists only with LV_WDG_SCAN_CRC_CHK_EN.
module lv_wdg_scan_ctrl
    import lv_wdg_scan_pkg::*;
#(
    parameter int                REG_AW          = 7,
    parameter int                REG_DW          = 8,
    parameter int                REG_CRC_W       = 8,
    parameter logic [REG_AW-1:0] SCAN_START_ADDR = 7'h00,
    parameter logic [REG_AW-1:0] SCAN_END_ADDR   = 7'h1F,
    parameter int                ACK_TIMEOUT     = 16,
    parameter int                MAX_RETRY       = 2,
    parameter int                SCAN_GAP        = 256
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_scan_en,
    input  logic                 i_err_clr,
    output logic                 o_wdg_scan_rac_rd_req,
    output logic [REG_AW-1:0]    o_wdg_scan_rac_addr,
    input  logic                 i_rac_wdg_scan_ack,
    input  logic [REG_DW-1:0]    i_rac_wdg_scan_data,
    input  logic [REG_CRC_W-1:0] i_rac_wdg_scan_crc,
    output logic                 o_scan_busy,
    output logic                 o_scan_done,
    output logic                 o_scan_crc_err,
    output logic                 o_scan_timeout,
    output logic                 o_scan_err_sticky,
    output logic [REG_AW-1:0]    o_scan_err_addr
);

    localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GAP_W = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((SCAN_GAP > 0) ? SCAN_GAP - 1 : 0);

    scan_state_e      state;
    logic [TMO_W-1:0] tmo_cnt;
    logic [RTY_W-1:0] retry_cnt;
    logic [GAP_W-1:0] gap_cnt;

    logic ack_ok;
    logic final_tmo;
    logic advance;
    logic at_end;
    logic crc_mismatch;

    // Acks only count while a request is actually on the bus.
    assign ack_ok    = (state == ST_REQ) && o_wdg_scan_rac_rd_req && i_rac_wdg_scan_ack;
    assign final_tmo = (state == ST_REQ) && o_wdg_scan_rac_rd_req && !i_rac_wdg_scan_ack
                       && (tmo_cnt == TMO_LAST) && (retry_cnt == RTY_MAX);
    assign advance   = (state == ST_CHK) || final_tmo;
    assign at_end    = (o_wdg_scan_rac_addr == SCAN_END_ADDR);

`ifdef LV_WDG_SCAN_CRC_CHK_EN
    logic [REG_DW-1:0]    cap_data;
    logic [REG_CRC_W-1:0] cap_crc;
    logic [7:0]           calc_crc;

    // NOTE: capture registers carry no reset; they are loaded on every accepted ack before CHK reads them.
    always_ff @(posedge i_clk) begin
        if (ack_ok) begin
            cap_data <= i_rac_wdg_scan_data;
            cap_crc  <= i_rac_wdg_scan_crc;
        end
    end

    lv_wdg_scan_crc8 #(.DW(REG_DW)) u_crc8 (
        .data (cap_data),
        .crc  (calc_crc)
    );

    assign crc_mismatch = (calc_crc != cap_crc);
`else
    logic unused_rac_payload;
    assign unused_rac_payload = ^{i_rac_wdg_scan_data, i_rac_wdg_scan_crc};
    assign crc_mismatch       = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state                 <= ST_IDLE;
            o_wdg_scan_rac_rd_req <= 1'b0;
            o_wdg_scan_rac_addr   <= SCAN_START_ADDR;
            o_scan_busy           <= 1'b0;
            o_scan_done           <= 1'b0;
            o_scan_crc_err        <= 1'b0;
            o_scan_timeout        <= 1'b0;
            o_scan_err_sticky     <= 1'b0;
            o_scan_err_addr       <= '0;
            tmo_cnt               <= '0;
            retry_cnt             <= '0;
            gap_cnt               <= '0;
        end else begin
            o_scan_done    <= 1'b0;
            o_scan_crc_err <= 1'b0;
            o_scan_timeout <= 1'b0;
            // Error sets below are later assignments, so a set beats a same-cycle clear.
            if (i_err_clr) o_scan_err_sticky <= 1'b0;

            if (!i_scan_en) begin
                state                 <= ST_IDLE;
                o_wdg_scan_rac_rd_req <= 1'b0;
                o_scan_busy           <= 1'b0;
                tmo_cnt               <= '0;
                retry_cnt             <= '0;
                gap_cnt               <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state                 <= ST_REQ;
                        o_wdg_scan_rac_addr   <= SCAN_START_ADDR;
                        o_wdg_scan_rac_rd_req <= 1'b1;
                        o_scan_busy           <= 1'b1;
                        tmo_cnt               <= '0;
                        retry_cnt             <= '0;
                    end
                    ST_REQ: begin
                        if (!o_wdg_scan_rac_rd_req) begin
                            o_wdg_scan_rac_rd_req <= 1'b1;
                        end else if (ack_ok) begin
                            state                 <= ST_CHK;
                            o_wdg_scan_rac_rd_req <= 1'b0;
                        end else if (tmo_cnt == TMO_LAST) begin
                            o_wdg_scan_rac_rd_req <= 1'b0;
                            tmo_cnt               <= '0;
                            if (retry_cnt != RTY_MAX) begin
                                retry_cnt <= retry_cnt + 1'b1;
                            end else begin
                                o_scan_timeout    <= 1'b1;
                                o_scan_err_sticky <= 1'b1;
                                o_scan_err_addr   <= o_wdg_scan_rac_addr;
                            end
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    ST_CHK: begin
                        if (crc_mismatch) begin
                            o_scan_crc_err    <= 1'b1;
                            o_scan_err_sticky <= 1'b1;
                            o_scan_err_addr   <= o_wdg_scan_rac_addr;
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt == GAP_LAST) begin
                            state                 <= ST_REQ;
                            o_wdg_scan_rac_addr   <= SCAN_START_ADDR;
                            o_wdg_scan_rac_rd_req <= 1'b1;
                            gap_cnt               <= '0;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase

                // After a final timeout the request stays low one cycle before the next address.
                if (advance) begin
                    retry_cnt <= '0;
                    tmo_cnt   <= '0;
                    gap_cnt   <= '0;
                    if (!at_end) begin
                        state                 <= ST_REQ;
                        o_wdg_scan_rac_addr   <= o_wdg_scan_rac_addr + 1'b1;
                        o_wdg_scan_rac_rd_req <= (state == ST_CHK);
                    end else begin
                        o_scan_done         <= 1'b1;
                        o_wdg_scan_rac_addr <= SCAN_START_ADDR;
                        if (SCAN_GAP == 0) begin
                            state                 <= ST_REQ;
                            o_wdg_scan_rac_rd_req <= (state == ST_CHK);
                        end else begin
                            state                 <= ST_GAP;
                            o_wdg_scan_rac_rd_req <= 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lv_wdg_scan_ctrl.sv
// Directed bench for lv_wdg_scan_ctrl: window 0x06..0x08, ACK_TIMEOUT=16,
// MAX_RETRY=2, SCAN_GAP=5, with a small ack responder driven every cycle.
module tb_lv_wdg_scan_ctrl;

`ifdef LV_WDG_SCAN_CRC_CHK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic       i_clk;
    logic       i_rst;
    logic       i_scan_en;
    logic       i_err_clr;
    logic       o_rd_req;
    logic [6:0] o_addr;
    logic       i_ack;
    logic [7:0] i_data;
    logic [7:0] i_crc;
    logic       o_busy;
    logic       o_done;
    logic       o_crc_err;
    logic       o_timeout;
    logic       o_sticky;
    logic [6:0] o_err_addr;

    lv_wdg_scan_ctrl #(
        .REG_AW          (7),
        .REG_DW          (8),
        .REG_CRC_W       (8),
        .SCAN_START_ADDR (7'h06),
        .SCAN_END_ADDR   (7'h08),
        .ACK_TIMEOUT     (16),
        .MAX_RETRY       (2),
        .SCAN_GAP        (5)
    ) dut (
        .i_clk                 (i_clk),
        .i_rst                 (i_rst),
        .i_scan_en             (i_scan_en),
        .i_err_clr             (i_err_clr),
        .o_wdg_scan_rac_rd_req (o_rd_req),
        .o_wdg_scan_rac_addr   (o_addr),
        .i_rac_wdg_scan_ack    (i_ack),
        .i_rac_wdg_scan_data   (i_data),
        .i_rac_wdg_scan_crc    (i_crc),
        .o_scan_busy           (o_busy),
        .o_scan_done           (o_done),
        .o_scan_crc_err        (o_crc_err),
        .o_scan_timeout        (o_timeout),
        .o_scan_err_sticky     (o_sticky),
        .o_scan_err_addr       (o_err_addr)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    int         rise_cyc[$];
    logic [6:0] rise_addr[$];
    int         n_done, n_crc, n_tmo;
    int         done_cyc, crc_cyc, tmo_cyc;

    bit         prev_req  = 1'b0;
    int         age       = 0;
    int         resp_lat  = 2;
    logic [6:0] mute_addr = 7'h7F;
    logic [6:0] bad_addr  = 7'h7F;

    int t_ref;
    int r0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_crc8(input logic [7:0] d);
        logic [7:0] c;
        c = 8'hFF ^ d;
        repeat (8) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    task automatic clear_log();
        rise_cyc.delete();
        rise_addr.delete();
        n_done = 0;
        n_crc  = 0;
        n_tmo  = 0;
    endtask

    // Advance one cycle, sample outputs 1 time unit after the edge, then drive the responder.
    task automatic tick();
        @(posedge i_clk);
        #1;
        cyc++;
        if (o_rd_req && !prev_req) begin
            rise_cyc.push_back(cyc);
            rise_addr.push_back(o_addr);
        end
        if (o_done)    begin n_done++; done_cyc = cyc; end
        if (o_crc_err) begin n_crc++;  crc_cyc  = cyc; end
        if (o_timeout) begin n_tmo++;  tmo_cyc  = cyc; end
        if (o_rd_req) age = prev_req ? age + 1 : 0;
        prev_req = o_rd_req;
        i_ack  = o_rd_req && (age == resp_lat) && (o_addr != mute_addr);
        i_data = {1'b0, o_addr} ^ 8'hA5;
        i_crc  = ref_crc8(i_data) ^ ((o_addr == bad_addr) ? 8'h01 : 8'h00);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        i_rst     = 1'b1;
        i_scan_en = 1'b0;
        i_err_clr = 1'b0;
        i_ack     = 1'b0;
        i_data    = 8'h00;
        i_crc     = 8'h00;
        clear_log();

        // Reset state
        tick_n(3);
        check("rst_rd_req",   32'(o_rd_req),   0);
        check("rst_busy",     32'(o_busy),     0);
        check("rst_addr",     32'(o_addr),     32'h06);
        check("rst_err_addr", 32'(o_err_addr), 0);
        check("rst_sticky",   32'(o_sticky),   0);
        check("rst_pulses",   32'({o_done, o_crc_err, o_timeout}), 0);
        i_rst = 1'b0;
        tick_n(2);
        check("idle_busy", 32'(o_busy), 0);

        // Clean sweep, gap, restart
        clear_log();
        i_scan_en = 1'b1;
        t_ref = cyc;
        tick();
        r0 = cyc;
        tick_n(17);
        check("sw_rise_cnt",   32'(rise_cyc.size()), 4);
        check("sw_first_lat",  rise_cyc[0] - t_ref, 1);
        check("sw_addr0",      32'(rise_addr[0]), 32'h06);
        check("sw_addr1",      32'(rise_addr[1]), 32'h07);
        check("sw_addr2",      32'(rise_addr[2]), 32'h08);
        check("sw_addr3",      32'(rise_addr[3]), 32'h06);
        check("sw_per_addr0",  rise_cyc[1] - rise_cyc[0], 4);
        check("sw_per_addr1",  rise_cyc[2] - rise_cyc[1], 4);
        check("sw_done_cnt",   n_done, 1);
        check("sw_done_time",  done_cyc - rise_cyc[2], 4);
        check("sw_gap_len",    rise_cyc[3] - done_cyc, 5);
        check("sw_no_err",     n_crc + n_tmo, 0);
        check("sw_busy",       32'(o_busy), 1);

        // Bad CRC on 0x07 in the next sweep
        clear_log();
        bad_addr = 7'h07;
        r0 = rise_cyc.size() == 0 ? cyc : cyc;
        tick_n(13);
        check("crc_done_cnt", n_done, 1);
        check("crc_err_cnt",  n_crc, 32'(CRC_EN));
        check("crc_err_addr", 32'(o_err_addr), CRC_EN ? 32'h07 : 32'h00);
        check("crc_sticky",   32'(o_sticky), 32'(CRC_EN));
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        check("crc_clr_sticky", 32'(o_sticky), 0);
        bad_addr = 7'h7F;

        // Ack on the last cycle of the timeout window is accepted
        i_scan_en = 1'b0;
        tick_n(2);
        clear_log();
        resp_lat  = 15;
        i_scan_en = 1'b1;
        tick();
        tick_n(17);
        check("late_rise_cnt", 32'(rise_cyc.size()), 2);
        check("late_interval", rise_cyc[1] - rise_cyc[0], 17);
        check("late_next_addr", 32'(rise_addr[1]), 32'h07);
        check("late_no_tmo",   n_tmo, 0);
        check("late_sticky",   32'(o_sticky), 0);

        // No ack at 0x06: two retries, then timeout; clear collides with the set
        i_scan_en = 1'b0;
        tick_n(2);
        clear_log();
        resp_lat  = 2;
        mute_addr = 7'h06;
        i_scan_en = 1'b1;
        tick();
        r0 = cyc;
        tick_n(49);
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        check("tmo_pulse",     32'(o_timeout), 1);
        check("tmo_cnt",       n_tmo, 1);
        check("tmo_time",      tmo_cyc - r0, 50);
        check("tmo_rise_cnt",  32'(rise_cyc.size()), 3);
        check("tmo_retry1",    rise_cyc[1] - rise_cyc[0], 17);
        check("tmo_retry2",    rise_cyc[2] - rise_cyc[1], 17);
        check("tmo_retry_addr", 32'(rise_addr[2]), 32'h06);
        check("tmo_sticky_set_wins", 32'(o_sticky), 1);
        check("tmo_err_addr",  32'(o_err_addr), 32'h06);
        tick();
        mute_addr = 7'h7F;
        check("tmo_next_rise", 32'(rise_cyc.size()), 4);
        check("tmo_next_addr", 32'(rise_addr[3]), 32'h07);
        check("tmo_next_time", rise_cyc[3] - tmo_cyc, 1);

        // Disable while in REQ, then a stray ack
        clear_log();
        resp_lat  = 99;
        i_scan_en = 1'b0;
        tick();
        check("dis_rd_req", 32'(o_rd_req), 0);
        check("dis_busy",   32'(o_busy), 0);
        i_ack = 1'b1;
        tick();
        tick_n(3);
        check("dis_no_events", n_done + n_crc + n_tmo, 0);
        check("dis_err_addr",  32'(o_err_addr), 32'h06);
        check("dis_sticky",    32'(o_sticky), 1);

        // Reset mid-sweep at 0x07, then rescan from the window start
        clear_log();
        resp_lat  = 2;
        i_scan_en = 1'b1;
        tick();
        tick_n(4);
        check("mid_req_addr", 32'({o_rd_req, o_addr}), 32'h87);
        i_rst = 1'b1;
        tick();
        check("mrst_rd_req",   32'(o_rd_req),   0);
        check("mrst_busy",     32'(o_busy),     0);
        check("mrst_addr",     32'(o_addr),     32'h06);
        check("mrst_err_addr", 32'(o_err_addr), 0);
        check("mrst_sticky",   32'(o_sticky),   0);
        check("mrst_pulses",   32'({o_done, o_crc_err, o_timeout}), 0);
        i_rst = 1'b0;
        clear_log();
        t_ref = cyc;
        tick();
        check("rescan_rise", 32'(rise_cyc.size()), 1);
        check("rescan_addr", 32'(rise_addr[0]), 32'h06);
        check("rescan_lat",  rise_cyc[0] - t_ref, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
